// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, queue entry
// layout and parameter defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetchState_t;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } qEntry_t;

    localparam int         QDEPTH_DEFAULT  = 2;
    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    // Pointer width that still works for a single-entry queue.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: circular buffer of {instruction, fetch address} pairs with
// a combinational head read and a flush that empties it in one edge.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH = QDEPTH_DEFAULT,
    localparam int PW    = ptrWidth(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [15:0]   pushData,
    input  logic [15:0]   pushPc,
    output logic [15:0]   headData,
    output logic [15:0]   headPc,
    output logic [CW-1:0] count
);

    qEntry_t          slots [DEPTH];
    logic [PW-1:0]    wrPtrReg;
    logic [PW-1:0]    rdPtrReg;
    logic [CW-1:0]    countReg;
    logic             doPush;
    logic             doPop;
    logic [DEPTH-1:0] slotWe;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push on a full queue is only accepted when the head leaves the same cycle.
    assign doPop  = pop && (countReg != '0) && !flush;
    assign doPush = push && !flush && ((countReg != CW'(DEPTH)) || doPop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slotWe
            assign slotWe[gi] = doPush && (wrPtrReg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slotWe[i]) begin
                slots[i] <= '{data: pushData, pc: pushPc};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else if (flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= bump(wrPtrReg);
            end
            if (doPop) begin
                rdPtrReg <= bump(rdPtrReg);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

    assign headData = slots[rdPtrReg].data;
    assign headPc   = slots[rdPtrReg].pc;
    assign count    = countReg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, buffers returned
// words in a small queue for decode, and handles branch redirects and HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int         QDEPTH  = QDEPTH_DEFAULT,
    parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic        redirect,
    output logic        pc_adv,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    input  logic        id_ready,
    output logic        halted
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetchState_t   stateReg;
    fetchState_t   stateNext;
    logic          dropReg;
    logic          dropNext;
    logic [15:0]   memAddrReg;
    logic [15:0]   memAddrNext;
    logic [CW-1:0] occupancy;
    logic [CW:0]   occAfterPush;
    logic          hasSpace;
    logic          spaceAfterPush;
    logic          isHaltOp;
    logic          qPush;
    logic          qPop;
    logic          qFlush;

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (qPush),
        .pop      (qPop),
        .flush    (qFlush),
        .pushData (mem_rdata),
        .pushPc   (memAddrReg),
        .headData (inst),
        .headPc   (inst_pc),
        .count    (occupancy)
    );

    assign inst_valid = (occupancy != '0);
    assign qPop       = inst_valid && id_ready;
    // Once halted the queue keeps draining even if the branch unit redirects.
    assign qFlush     = redirect && (stateReg != HALT);

    assign hasSpace       = (occupancy < CW'(QDEPTH));
    assign occAfterPush   = {1'b0, occupancy} + (CW + 1)'(1) - (CW + 1)'(qPop);
    assign spaceAfterPush = (occAfterPush < (CW + 1)'(QDEPTH));
    assign isHaltOp       = (mem_rdata[15:12] == HALT_OP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg   <= IDLE;
            dropReg    <= 1'b0;
            memAddrReg <= '0;
        end else begin
            stateReg   <= stateNext;
            dropReg    <= dropNext;
            memAddrReg <= memAddrNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        dropNext    = dropReg;
        memAddrNext = memAddrReg;
        qPush       = 1'b0;
        case (stateReg)
            IDLE: begin
                if (hasSpace && !redirect) begin
                    stateNext   = REQ;
                    memAddrNext = pc;
                end
            end
            REQ: begin
                // Address stays frozen until granted; a redirect only marks the
                // in-progress fetch as stale.
                if (redirect) begin
                    dropNext = 1'b1;
                end
                if (mem_gnt) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    if (dropReg || redirect) begin
                        dropNext    = 1'b0;
                        stateNext   = REQ;
                        memAddrNext = pc;
                    end else begin
                        qPush = 1'b1;
                        if (isHaltOp) begin
                            stateNext = HALT;
                        end else if (spaceAfterPush) begin
                            stateNext   = REQ;
                            memAddrNext = pc;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end else if (redirect) begin
                    dropNext = 1'b1;
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        pc_adv  = 1'b0;
        halted  = 1'b0;
        case (stateReg)
            REQ: begin
                mem_req = 1'b1;
                pc_adv  = mem_gnt && !dropReg;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign mem_addr = memAddrReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/decode/branch
// traffic, compared every cycle against a transaction-level reference model.
module tb_fetch_unit;

    localparam int         QD   = 2;
    localparam logic [3:0] HOP  = 4'hF;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic        redirect;
    logic        pc_adv;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        id_ready;
    logic        halted;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .redirect   (redirect),
        .pc_adv     (pc_adv),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .id_ready   (id_ready),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
    } entry_t;

    // Reference model: queue contents plus the status of the single fetch slot.
    entry_t      mq[$];
    bit          mReqOpen;
    bit          mInFlight;
    bit          mDiscard;
    bit          mStopped;
    logic [15:0] mAddr;

    int nChecks = 0;
    int nBad    = 0;
    int advCount = 0;
    int reqCount = 0;
    logic lastReq;

    logic        drvRst;
    logic        drvRedirect;
    logic [15:0] drvTarget;
    logic        drvGnt;
    logic        drvValid;
    logic [15:0] drvRdata;
    logic        drvReady;
    logic [15:0] pcCur;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] memWord(input logic [15:0] a);
        logic [3:0] op;
        op = a[5:2];
        if (op == HOP) op = 4'h3;
        return {op, a[11:0] ^ 12'h3C5};
    endfunction

    task automatic modelReset();
        mq.delete();
        mReqOpen  = 1'b0;
        mInFlight = 1'b0;
        mDiscard  = 1'b0;
        mStopped  = 1'b0;
        mAddr     = 16'h0000;
    endtask

    task automatic openFetch();
        mReqOpen = 1'b1;
        mAddr    = pcCur;
    endtask

    task automatic modelEdge();
        int     sz;
        bit     doPop;
        entry_t e;
        sz    = mq.size();
        doPop = (sz != 0) && drvReady;
        if (mStopped) begin
            if (doPop) void'(mq.pop_front());
        end else begin
            if (drvRedirect) mq.delete();
            else if (doPop) void'(mq.pop_front());
            if (mReqOpen) begin
                if (drvRedirect) mDiscard = 1'b1;
                if (drvGnt) begin
                    mReqOpen  = 1'b0;
                    mInFlight = 1'b1;
                end
            end else if (mInFlight) begin
                if (drvValid) begin
                    mInFlight = 1'b0;
                    if (mDiscard || drvRedirect) begin
                        mDiscard = 1'b0;
                        openFetch();
                    end else begin
                        e.data = drvRdata;
                        e.addr = mAddr;
                        mq.push_back(e);
                        if (drvRdata[15:12] == HOP) mStopped = 1'b1;
                        else if (mq.size() < QD) openFetch();
                    end
                end else if (drvRedirect) begin
                    mDiscard = 1'b1;
                end
            end else if (sz < QD && !drvRedirect) begin
                openFetch();
            end
        end
    endtask

    task automatic clearDrv();
        drvRedirect = 1'b0;
        drvGnt      = 1'b0;
        drvValid    = 1'b0;
        drvRdata    = 16'h0000;
    endtask

    // One clock: apply inputs, compare at the falling edge, advance the model.
    task automatic step();
        logic eReq;
        logic eAdv;
        rst = drvRst;
        redirect = drvRedirect;
        if (drvRedirect) pcCur = drvTarget;
        pc        = pcCur;
        mem_gnt   = drvGnt;
        mem_valid = drvValid;
        mem_rdata = drvRdata;
        id_ready  = drvReady;
        if (!drvRst) modelReset();
        @(negedge clk);
        eReq = mReqOpen && !mStopped;
        eAdv = mReqOpen && drvGnt && !mDiscard;
        checkVal("mem_req",    {15'd0, mem_req},    {15'd0, eReq});
        checkVal("mem_addr",   mem_addr,            mAddr);
        checkVal("pc_adv",     {15'd0, pc_adv},     {15'd0, eAdv});
        checkVal("inst_valid", {15'd0, inst_valid}, {15'd0, mq.size() != 0});
        checkVal("halted",     {15'd0, halted},     {15'd0, mStopped});
        if (mq.size() != 0) begin
            checkVal("inst",    inst,    mq[0].data);
            checkVal("inst_pc", inst_pc, mq[0].addr);
            if (drvReady && drvRst)
                $display("deq pc=%h inst=%h @%0t", mq[0].addr, mq[0].data, $time);
        end
        lastReq = mem_req;
        if (pc_adv) advCount++;
        if (mem_req) reqCount++;
        if (drvRst) modelEdge();
        @(posedge clk);
        #1;
        if (drvRst && !drvRedirect && eAdv) pcCur = pcCur + 16'd2;
    endtask

    task automatic fetchOne(input logic [15:0] data, input int lat, input bit popWithValid);
        int n;
        n = 0;
        clearDrv();
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checkVal("req_wait", {15'd0, mem_req}, 16'd1);
        drvGnt = 1'b1;
        step();
        drvGnt = 1'b0;
        for (int i = 1; i < lat; i++) step();
        drvValid = 1'b1;
        drvRdata = data;
        if (popWithValid) drvReady = 1'b1;
        step();
        clearDrv();
        if (popWithValid) drvReady = 1'b0;
    endtask

    int          advBase;
    int          reqBase;
    bit          respBusy;
    int          respCnt;
    logic [15:0] respAddr;

    initial begin
        pcCur    = 16'h0000;
        drvRst   = 1'b0;
        drvReady = 1'b0;
        drvTarget = 16'h0000;
        clearDrv();
        modelReset();
        rst = 1'b0;

        // Reset values.
        for (int i = 0; i < 3; i++) step();
        checkVal("rst_req",   {15'd0, mem_req},    16'd0);
        checkVal("rst_valid", {15'd0, inst_valid}, 16'd0);
        checkVal("rst_halt",  {15'd0, halted},     16'd0);
        checkVal("rst_addr",  mem_addr,            16'h0000);
        drvRst = 1'b1;

        // Single fetch at pc 0, grant immediately, data two cycles later.
        advBase = advCount;
        fetchOne(16'h1234, 2, 1'b0);
        checkVal("t034_inst",  inst,                 16'h1234);
        checkVal("t034_pc",    inst_pc,              16'h0000);
        checkVal("t034_adv",   16'(advCount - advBase), 16'd1);

        // Second fetch fills the queue; fetching stalls until decode takes one.
        fetchOne(16'h2222, 1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        checkVal("t035_idle", {15'd0, mem_req}, 16'd0);
        drvReady = 1'b1;
        step();
        drvReady = 1'b0;
        step();
        checkVal("t035_req",  {15'd0, mem_req}, 16'd1);
        checkVal("t035_addr", mem_addr,         16'h0004);
        checkVal("t035_head", inst,             16'h2222);

        // Enqueue and dequeue on the same edge keeps FIFO order.
        fetchOne(16'h3333, 1, 1'b1);
        checkVal("t038_valid", {15'd0, inst_valid}, 16'd1);
        checkVal("t038_inst",  inst,                16'h3333);
        checkVal("t038_pc",    inst_pc,             16'h0004);
        drvReady = 1'b1;
        step();
        drvReady = 1'b0;

        // Redirect while requesting: grant is dropped, no pc_adv.
        advBase = advCount;
        drvRedirect = 1'b1;
        drvTarget   = 16'h0010;
        step();
        clearDrv();
        fetchOne(16'h7777, 1, 1'b0);
        checkVal("t025_adv",   16'(advCount - advBase), 16'd0);
        checkVal("t025_addr",  mem_addr,               16'h0010);
        checkVal("t025_valid", {15'd0, inst_valid},    16'd0);

        // Redirect while waiting: response discarded, refetch at target.
        advBase = advCount;
        drvGnt = 1'b1;
        step();
        clearDrv();
        drvRedirect = 1'b1;
        drvTarget   = 16'h0040;
        step();
        clearDrv();
        drvValid = 1'b1;
        drvRdata = 16'h5555;
        step();
        clearDrv();
        checkVal("t036_addr",  mem_addr,               16'h0040);
        checkVal("t036_req",   {15'd0, mem_req},       16'd1);
        checkVal("t036_valid", {15'd0, inst_valid},    16'd0);
        checkVal("t036_adv",   16'(advCount - advBase), 16'd1);

        // HALT opcode stops fetching; redirect is ignored, queue still drains.
        fetchOne(16'hF000, 2, 1'b0);
        checkVal("t037_halt", {15'd0, halted}, 16'd1);
        reqBase = reqCount;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                drvRedirect = 1'b1;
                drvTarget   = 16'h0080;
            end
            step();
            clearDrv();
        end
        checkVal("t037_noreq", 16'(reqCount - reqBase), 16'd0);
        checkVal("t037_inst",  inst,                    16'hF000);
        checkVal("t037_pc",    inst_pc,                 16'h0040);
        drvReady = 1'b1;
        step();
        drvReady = 1'b0;
        checkVal("t037_drain", {15'd0, inst_valid}, 16'd0);
        checkVal("t037_held",  {15'd0, halted},     16'd1);

        // Reset clears HALT; reset mid-request then a stray response.
        drvRst = 1'b0;
        step();
        step();
        checkVal("t039_unhalt", {15'd0, halted}, 16'd0);
        drvRst = 1'b1;
        step();
        checkVal("t039_req", {15'd0, mem_req}, 16'd1);
        drvRst = 1'b0;
        step();
        drvRst   = 1'b1;
        drvValid = 1'b1;
        drvRdata = 16'h9999;
        step();
        clearDrv();
        checkVal("t039_idle",  {15'd0, lastReq},    16'd0);
        checkVal("t039_valid", {15'd0, inst_valid}, 16'd0);

        // Randomized traffic against the model.
        respBusy = 1'b0;
        respCnt  = 0;
        respAddr = 16'h0000;
        for (int c = 0; c < 1500; c++) begin
            clearDrv();
            drvReady = ($urandom % 2) == 0;
            if (respBusy) begin
                respCnt--;
                if (respCnt == 0) begin
                    drvValid = 1'b1;
                    drvRdata = memWord(respAddr);
                    respBusy = 1'b0;
                end
            end else if (mReqOpen && ($urandom % 3) != 0) begin
                drvGnt   = 1'b1;
                respBusy = 1'b1;
                respAddr = mAddr;
                respCnt  = int'($urandom_range(1, 3));
            end
            if (($urandom % 20) == 0) begin
                drvRedirect = 1'b1;
                drvTarget   = 16'($urandom) & 16'hFFFE;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
